// File: rtl/mult_seq_if.sv
// Handshake and operand/result bundle for the iterative multiplier.
// The master drives requests; the slave (mult_seq) returns status and product.
interface mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic             i_is_signed;
   logic             i_abort;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_prod_hi;
   logic [WIDTH-1:0] o_prod_lo;

   modport master (
      output i_start, i_is_signed, i_abort, i_a, i_b,
      input  o_busy, o_done, o_prod_hi, o_prod_lo
   );

   modport slave (
      input  i_start, i_is_signed, i_abort, i_a, i_b,
      output o_busy, o_done, o_prod_hi, o_prod_lo
   );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier: full 2*WIDTH-bit product, optional signed mode,
// start/busy/done handshake with abort. Signed operands are multiplied as magnitudes.
module mult_seq #(
   parameter int WIDTH     = 32,
   parameter int SIGNED_EN = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   mult_seq_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [CW-1:0]      r_cnt;
   logic               r_neg;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_prod_hi;
   logic [WIDTH-1:0]   r_prod_lo;

   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_mcand_nxt;
   logic [WIDTH-1:0]   w_hi_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;
   logic [CW-1:0]      w_cnt_nxt;
   logic               w_neg_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic [WIDTH-1:0]   w_prod_hi_nxt;
   logic [WIDTH-1:0]   w_prod_lo_nxt;

   logic               w_sgn_mode;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_addend;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_full;
   logic [2*WIDTH-1:0] w_res;

   // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
   assign w_sgn_mode = (SIGNED_EN != 0) ? bus.i_is_signed : 1'b0;
   assign w_a_mag    = (w_sgn_mode && bus.i_a[WIDTH-1]) ? (~bus.i_a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.i_a;
   assign w_b_mag    = (w_sgn_mode && bus.i_b[WIDTH-1]) ? (~bus.i_b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.i_b;

   // The adder is one bit wider so the carry survives into the shift.
   assign w_addend = r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}};
   assign w_sum    = {1'b0, r_hi} + w_addend;

   assign w_full = {r_hi, r_lo};
   assign w_res  = r_neg ? (~w_full + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_full;

   // State register and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_mcand   <= {WIDTH{1'b0}};
         r_hi      <= {WIDTH{1'b0}};
         r_lo      <= {WIDTH{1'b0}};
         r_cnt     <= {CW{1'b0}};
         r_neg     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_prod_hi <= {WIDTH{1'b0}};
         r_prod_lo <= {WIDTH{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_mcand   <= w_mcand_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_cnt     <= w_cnt_nxt;
         r_neg     <= w_neg_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_prod_hi <= w_prod_hi_nxt;
         r_prod_lo <= w_prod_lo_nxt;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      w_state_nxt   = r_state;
      w_mcand_nxt   = r_mcand;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_cnt_nxt     = r_cnt;
      w_neg_nxt     = r_neg;
      w_done_nxt    = 1'b0;
      w_prod_hi_nxt = r_prod_hi;
      w_prod_lo_nxt = r_prod_lo;

      case (r_state)
         S_IDLE: begin
            if (bus.i_start && !bus.i_abort) begin
               w_mcand_nxt = w_a_mag;
               w_lo_nxt    = w_b_mag;
               w_hi_nxt    = {WIDTH{1'b0}};
               w_neg_nxt   = w_sgn_mode & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
               w_cnt_nxt   = CW'(WIDTH);
               w_state_nxt = S_CALC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CALC: begin
            if (bus.i_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_hi_nxt  = w_sum[WIDTH:1];
               w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
               w_cnt_nxt = r_cnt - {{(CW-1){1'b0}}, 1'b1};
               if (r_cnt == {{(CW-1){1'b0}}, 1'b1}) begin
                  w_state_nxt = S_FIX;
               end else begin
                  w_state_nxt = S_CALC;
               end
            end
         end
         S_FIX: begin
            if (bus.i_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_prod_hi_nxt = w_res[2*WIDTH-1:WIDTH];
               w_prod_lo_nxt = w_res[WIDTH-1:0];
               w_done_nxt    = 1'b1;
               w_state_nxt   = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   assign bus.o_busy    = r_busy;
   assign bus.o_done    = r_done;
   assign bus.o_prod_hi = r_prod_hi;
   assign bus.o_prod_lo = r_prod_lo;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: an 8-bit and a 32-bit instance share clock and reset.
module tb_mult_seq;

   logic clk;
   logic reset_n;

   mult_seq_if #(.WIDTH(8))  if8();
   mult_seq_if #(.WIDTH(32)) if32();

   mult_seq #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if8)
   );

   mult_seq #(.WIDTH(32), .SIGNED_EN(1)) u_dut32 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if32)
   );

   int          n_cmp;
   int          n_err;
   int          n_done8;
   int          n_done32;
   logic [15:0] q8[$];
   logic [63:0] q32[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic [15:0] xa;
      logic [15:0] xb;
      xa = s ? {{8{a[7]}}, a} : {8'h00, a};
      xb = s ? {{8{b[7]}}, b} : {8'h00, b};
      return xa * xb;
   endfunction

   function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [63:0] xa;
      logic [63:0] xb;
      xa = s ? {{32{a[31]}}, a} : {32'h0, a};
      xb = s ? {{32{b[31]}}, b} : {32'h0, b};
      return xa * xb;
   endfunction

   // Scoreboard: every done pulse pops one expected product.
   always @(negedge clk) begin
      if (if8.o_done) begin
         n_done8++;
         if (q8.size() == 0) check_eq("sb8_spurious_done", 64'd1, 64'd0);
         else check_eq("sb8_product", {if8.o_prod_hi, if8.o_prod_lo}, q8.pop_front());
      end
      if (if32.o_done) begin
         n_done32++;
         if (q32.size() == 0) check_eq("sb32_spurious_done", 64'd1, 64'd0);
         else check_eq("sb32_product", {if32.o_prod_hi, if32.o_prod_lo}, q32.pop_front());
      end
   end

   // Drives start for one cycle from the current (negedge) time.
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push_exp);
      if8.i_start     = 1'b1;
      if8.i_a         = a;
      if8.i_b         = b;
      if8.i_is_signed = s;
      if (push_exp) q8.push_back(model8(a, b, s));
      @(negedge clk);
      if8.i_start = 1'b0;
   endtask

   // Called in cycle 1 after start; returns in the done cycle.
   task automatic wait_done8(output int cyc, output int bcyc);
      cyc  = 1;
      bcyc = 0;
      while (!if8.o_done && cyc < 60) begin
         if (if8.o_busy) bcyc++;
         @(negedge clk);
         cyc++;
      end
      if (!if8.o_done) check_eq("timeout8", 64'd0, 64'd1);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] spec, input string tag);
      int cyc;
      int bcyc;
      @(negedge clk);
      start8(a, b, s, 1'b1);
      wait_done8(cyc, bcyc);
      check_eq(tag, {if8.o_prod_hi, if8.o_prod_lo}, spec);
   endtask

   initial begin
      int          cyc;
      int          bcyc;
      int          base;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic        rs;

      n_cmp = 0; n_err = 0; n_done8 = 0; n_done32 = 0;
      reset_n = 1'b0;
      if8.i_start = 1'b0;  if8.i_abort = 1'b0;  if8.i_is_signed = 1'b0;  if8.i_a = 8'h0;  if8.i_b = 8'h0;
      if32.i_start = 1'b0; if32.i_abort = 1'b0; if32.i_is_signed = 1'b0; if32.i_a = 32'h0; if32.i_b = 32'h0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy8", if8.o_busy, 0);
      check_eq("rst_done8", if8.o_done, 0);
      check_eq("rst_prod8", {if8.o_prod_hi, if8.o_prod_lo}, 0);
      check_eq("rst_prod32", {if32.o_prod_hi, if32.o_prod_lo}, 0);
      reset_n = 1'b1;

      // 255*255 with latency check
      @(negedge clk);
      start8(8'hFF, 8'hFF, 1'b0, 1'b1);
      wait_done8(cyc, bcyc);
      check_eq("lat_busy_cycles", bcyc, 9);
      check_eq("lat_done_cycle", cyc, 10);
      check_eq("u255x255", {if8.o_prod_hi, if8.o_prod_lo}, 16'hFE01);

      op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
      op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
      op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_127xm128");
      op8(8'hFD, 8'h05, 1'b0, 16'h04F1, "u_fdx5");

      // abort in CALC cycle 3
      @(negedge clk);
      start8(8'd7, 8'd6, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      if8.i_abort = 1'b1;
      @(negedge clk);
      if8.i_abort = 1'b0;
      check_eq("abort_busy", if8.o_busy, 0);
      base = n_done8;
      repeat (12) @(negedge clk);
      check_eq("abort_no_done", n_done8 - base, 0);
      check_eq("abort_prod_held", {if8.o_prod_hi, if8.o_prod_lo}, 16'h04F1);

      op8(8'd7, 8'd6, 1'b0, 16'h002A, "after_abort_7x6");

      // back-to-back: start in the done cycle
      start8(8'd2, 8'd3, 1'b0, 1'b1);
      check_eq("done_one_cycle", if8.o_done, 0);
      check_eq("b2b_prod_held", {if8.o_prod_hi, if8.o_prod_lo}, 16'h002A);
      wait_done8(cyc, bcyc);
      check_eq("b2b_done_cycle", cyc, 10);
      check_eq("b2b_2x3", {if8.o_prod_hi, if8.o_prod_lo}, 16'h0006);

      // abort and start together in IDLE
      @(negedge clk);
      if8.i_start = 1'b1; if8.i_abort = 1'b1;
      @(negedge clk);
      if8.i_start = 1'b0; if8.i_abort = 1'b0;
      check_eq("abort_wins_idle", if8.o_busy, 0);

      // asynchronous reset mid-CALC
      @(negedge clk);
      start8(8'h12, 8'h34, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_eq("arst_busy", if8.o_busy, 0);
      check_eq("arst_prod", {if8.o_prod_hi, if8.o_prod_lo}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("arst_idle", if8.o_busy, 0);
      start8(8'h00, 8'h00, 1'b0, 1'b1);
      wait_done8(cyc, bcyc);
      check_eq("arst_0x0_cycle", cyc, 10);

      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         @(negedge clk);
         start8(ra, rb, rs, 1'b1);
         wait_done8(cyc, bcyc);
      end

      // 32-bit full scale, start held during busy
      @(negedge clk);
      if32.i_start = 1'b1; if32.i_is_signed = 1'b0;
      if32.i_a = 32'hFFFFFFFF; if32.i_b = 32'hFFFFFFFF;
      q32.push_back(model32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
      base = n_done32;
      @(negedge clk);
      if32.i_a = 32'd3; if32.i_b = 32'd5;
      cyc = 1;
      while (!if32.o_done && cyc < 80) begin
         if (cyc == 20) if32.i_start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check_eq("w32_done_cycle", cyc, 34);
      check_eq("w32_full", {if32.o_prod_hi, if32.o_prod_lo}, 64'hFFFFFFFE_00000001);
      repeat (10) @(negedge clk);
      check_eq("w32_one_done", n_done32 - base, 1);

      @(negedge clk);
      if32.i_start = 1'b1; if32.i_is_signed = 1'b1;
      if32.i_a = 32'h80000000; if32.i_b = 32'hFFFFFFFF;
      q32.push_back(model32(32'h80000000, 32'hFFFFFFFF, 1'b1));
      @(negedge clk);
      if32.i_start = 1'b0;
      repeat (40) @(negedge clk);

      check_eq("sb8_drained", q8.size(), 0);
      check_eq("sb32_drained", q32.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
